// File: rtl/ehl_gpio_master.sv
// Command-queued register-bus master: FIFO of write/read/RMW commands executed one at a
// time against a simple strobe-based target, with a held response channel.
module ehl_gpio_master #(
  parameter int WIDTH        = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [5:0]       cmd_addr,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic             wr,
  output logic             rd,
  output logic [5:0]       addr,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic [WIDTH-1:0] bus_rdata,
  input  logic             bus_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic LAT1 = (READ_LATENCY != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_RDWAIT = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_RMW = 2'b10;

  logic [1:0]       r_fop   [FIFO_DEPTH];
  logic [5:0]       r_faddr [FIFO_DEPTH];
  logic [WIDTH-1:0] r_fdata [FIFO_DEPTH];
  logic [WIDTH-1:0] r_fmask [FIFO_DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;

  logic [2:0]       r_state, w_state_nxt;
  logic [1:0]       r_op;
  logic [5:0]       r_caddr;
  logic [WIDTH-1:0] r_cdata, r_cmask, r_old;
  logic             r_wr, r_rd, r_rsp_valid, r_rsp_err;
  logic [5:0]       r_addr;
  logic [WIDTH-1:0] r_wdata, r_rsp_data;

  logic             w_full, w_empty, w_push, w_pop, w_cap;
  logic [5:0]       w_addr_nxt;
  logic [WIDTH-1:0] w_wdata_nxt;

  function automatic logic [WIDTH-1:0] rmw_merge(input logic [WIDTH-1:0] old_v,
                                                 input logic [WIDTH-1:0] new_v,
                                                 input logic [WIDTH-1:0] mask_v);
    return (old_v & ~mask_v) | (new_v & mask_v);
  endfunction

  assign w_full    = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_cnt == {(AW+1){1'b0}});
  assign w_push    = cmd_valid & ~w_full;
  assign w_pop     = (r_state == S_IDLE) & ~w_empty;
  assign w_cap     = LAT1 ? (r_state == S_RDWAIT) : (r_state == S_RD);
  assign cmd_ready = ~w_full;
  assign busy      = ~w_empty | (r_state != S_IDLE);

  assign wr        = r_wr;
  assign rd        = r_rd;
  assign addr      = r_addr;
  assign bus_wdata = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

  // FIFO payload storage; pointers alone define validity, so no reset needed here
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fop[r_wp]   <= cmd_op;
      r_faddr[r_wp] <= cmd_addr;
      r_fdata[r_wp] <= cmd_data;
      r_fmask[r_wp] <= cmd_mask;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= {AW{1'b0}};
      r_rp  <= {AW{1'b0}};
      r_cnt <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Next state plus the strobe address/data for the state being entered
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = 6'd0;
    w_wdata_nxt = {WIDTH{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          case (r_fop[r_rp])
            OP_WR: begin
              w_state_nxt = S_WR;
              w_addr_nxt  = r_faddr[r_rp];
              w_wdata_nxt = r_fdata[r_rp];
            end
            OP_RD, OP_RMW: begin
              w_state_nxt = S_RD;
              w_addr_nxt  = r_faddr[r_rp];
            end
            default: w_state_nxt = S_RESP;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD, S_RDWAIT: begin
        if (!w_cap) begin
          w_state_nxt = S_RDWAIT;
        end else if ((r_op == OP_RMW) && !bus_err) begin
          w_state_nxt = S_WR;
          w_addr_nxt  = r_caddr;
          w_wdata_nxt = rmw_merge(bus_rdata, r_cdata, r_cmask);
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_WR: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, current command, registered bus strobes and response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_caddr     <= 6'd0;
      r_cdata     <= {WIDTH{1'b0}};
      r_cmask     <= {WIDTH{1'b0}};
      r_old       <= {WIDTH{1'b0}};
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_addr      <= 6'd0;
      r_wdata     <= {WIDTH{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {WIDTH{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr        <= (w_state_nxt == S_WR);
      r_rd        <= (w_state_nxt == S_RD);
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_valid <= (w_state_nxt == S_RESP);
      if (w_pop) begin
        r_op    <= r_fop[r_rp];
        r_caddr <= r_faddr[r_rp];
        r_cdata <= r_fdata[r_rp];
        r_cmask <= r_fmask[r_rp];
        // reserved op answers straight away with an error and no bus access
        r_rsp_data <= {WIDTH{1'b0}};
        r_rsp_err  <= (r_fop[r_rp] == 2'b11);
      end
      if (w_cap) begin
        r_old      <= bus_rdata;
        r_rsp_data <= bus_rdata;
        r_rsp_err  <= bus_err;
      end
      if (r_state == S_WR) begin
        r_rsp_data <= (r_op == OP_RMW) ? r_old : {WIDTH{1'b0}};
        r_rsp_err  <= bus_err;
      end
    end
  end

endmodule

// File: tb/tb_ehl_gpio_master.sv
// Directed bench for ehl_gpio_master: one instance per read latency, a table of single
// commands, plus back-pressure and mid-operation reset sequences.
module tb_ehl_gpio_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cv, tb_sel, rsp_ready, tb_rerr, tb_werr;
  logic [1:0]  op;
  logic [5:0]  caddr;
  logic [31:0] cdata, cmask;
  logic [31:0] tmem [64];

  logic        cmd_valid0, cmd_ready0, wr0, rd0, rsp_valid0, rsp_err0, busy0, bus_err0;
  logic [5:0]  addr0;
  logic [31:0] wdata0, rsp_data0, bus_rdata0;
  logic        cmd_valid1, cmd_ready1, wr1, rd1, rsp_valid1, rsp_err1, busy1, bus_err1;
  logic [5:0]  addr1;
  logic [31:0] wdata1, rsp_data1, bus_rdata1;
  logic [31:0] q_rdata1;
  logic        q_err1;

  logic        m_wr, m_rd, m_rv, m_err;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata, m_data;

  int total = 0;
  int bad   = 0;

  assign cmd_valid0 = cv & ~tb_sel;
  assign cmd_valid1 = cv & tb_sel;

  ehl_gpio_master #(.WIDTH(32), .FIFO_DEPTH(4), .READ_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_op(op), .cmd_addr(caddr), .cmd_data(cdata), .cmd_mask(cmask),
    .wr(wr0), .rd(rd0), .addr(addr0), .bus_wdata(wdata0),
    .bus_rdata(bus_rdata0), .bus_err(bus_err0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0),
    .rsp_err(rsp_err0), .busy(busy0));

  ehl_gpio_master #(.WIDTH(32), .FIFO_DEPTH(4), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(op), .cmd_addr(caddr), .cmd_data(cdata), .cmd_mask(cmask),
    .wr(wr1), .rd(rd1), .addr(addr1), .bus_wdata(wdata1),
    .bus_rdata(bus_rdata1), .bus_err(bus_err1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1),
    .rsp_err(rsp_err1), .busy(busy1));

  // Targets: combinational for latency 0, registered (data one cycle after rd) for latency 1
  always_comb begin
    bus_rdata0 = rd0 ? tmem[addr0] : 32'h0BAD_F00D;
    bus_err0   = rd0 ? tb_rerr : (wr0 ? tb_werr : 1'b0);
    bus_rdata1 = q_rdata1;
    bus_err1   = wr1 ? tb_werr : q_err1;
  end

  always @(posedge clk) begin
    q_rdata1 <= rd1 ? tmem[addr1] : 32'h0BAD_F00D;
    q_err1   <= rd1 & tb_rerr;
  end

  always_comb begin
    m_wr    = tb_sel ? wr1        : wr0;
    m_rd    = tb_sel ? rd1        : rd0;
    m_addr  = tb_sel ? addr1      : addr0;
    m_wdata = tb_sel ? wdata1     : wdata0;
    m_rv    = tb_sel ? rsp_valid1 : rsp_valid0;
    m_data  = tb_sel ? rsp_data1  : rsp_data0;
    m_err   = tb_sel ? rsp_err1   : rsp_err0;
  end

  typedef struct {
    logic        sel;
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [31:0] data, mask, old;
    logic        rerr, werr;
    int          rd_cyc, wr_cyc;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int rdc = 0, wrc = 0, nrd = 0, nwr = 0, lat = 0;
    logic [31:0] wd = 32'h0, rdat = 32'h0;
    logic re = 1'b0, hyg = 1'b1, aok = 1'b1;
    @(negedge clk);
    tb_sel = v.sel; op = v.op; caddr = v.addr; cdata = v.data; cmask = v.mask;
    tmem[v.addr] = v.old; tb_rerr = v.rerr; tb_werr = v.werr; rsp_ready = 1'b1; cv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cv = 1'b0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (m_rd) begin nrd++; if (rdc == 0) rdc = k; if (m_addr != v.addr) aok = 1'b0; end
      if (m_wr) begin nwr++; if (wrc == 0) wrc = k; wd = m_wdata; if (m_addr != v.addr) aok = 1'b0; end
      if (m_wr && m_rd) hyg = 1'b0;
      if (!m_wr && !m_rd && (m_addr != 6'd0 || m_wdata != 32'h0)) hyg = 1'b0;
      if (m_rv) begin lat = k; rdat = m_data; re = m_err; end
    end
    chk($sformatf("vec%0d_rd_cycle", idx), rdc, v.rd_cyc);
    chk($sformatf("vec%0d_rd_count", idx), nrd, (v.rd_cyc != 0) ? 1 : 0);
    chk($sformatf("vec%0d_wr_cycle", idx), wrc, v.wr_cyc);
    chk($sformatf("vec%0d_wr_count", idx), nwr, (v.wr_cyc != 0) ? 1 : 0);
    chk($sformatf("vec%0d_wdata", idx), wd, v.wdata);
    chk($sformatf("vec%0d_addr", idx), {31'd0, aok}, 32'd1);
    chk($sformatf("vec%0d_idle_bus", idx), {31'd0, hyg}, 32'd1);
    chk($sformatf("vec%0d_rsp_latency", idx), lat, v.lat);
    chk($sformatf("vec%0d_rsp_data", idx), rdat, v.rdata);
    chk($sformatf("vec%0d_rsp_err", idx), {31'd0, re}, {31'd0, v.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] resp [8];
    int n, acc;
    logic rv_held, last_rdy, quiet;

    //   sel op     addr   data          mask          old           rerr werr rd wr wdata        lat rdata        err
    vecs[0]  = '{1'b0, 2'b00, 6'h04, 32'hA5A5A5A5, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 0, 2, 32'hA5A5A5A5, 3, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 6'h10, 32'h00000000, 32'h00000000, 32'hCAFEBABE, 1'b0, 1'b0, 2, 0, 32'h00000000, 3, 32'hCAFEBABE, 1'b0};
    vecs[2]  = '{1'b0, 2'b01, 6'h11, 32'h00000000, 32'h00000000, 32'h11112222, 1'b1, 1'b0, 2, 0, 32'h00000000, 3, 32'h11112222, 1'b1};
    vecs[3]  = '{1'b0, 2'b10, 6'h05, 32'h0000FFFF, 32'h000000F0, 32'hFF00FF00, 1'b0, 1'b0, 2, 3, 32'hFF00FFF0, 4, 32'hFF00FF00, 1'b0};
    vecs[4]  = '{1'b0, 2'b10, 6'h06, 32'h0000FFFF, 32'h000000F0, 32'h12345678, 1'b1, 1'b0, 2, 0, 32'h00000000, 3, 32'h12345678, 1'b1};
    vecs[5]  = '{1'b0, 2'b11, 6'h3F, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 0, 0, 32'h00000000, 2, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b0, 2'b00, 6'h21, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 0, 2, 32'h00000001, 3, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 2'b10, 6'h22, 32'hFFFF0000, 32'hFFFFFFFF, 32'h000000FF, 1'b0, 1'b1, 2, 3, 32'hFFFF0000, 4, 32'h000000FF, 1'b1};
    vecs[8]  = '{1'b1, 2'b01, 6'h08, 32'h00000000, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 2, 0, 32'h00000000, 4, 32'h12345678, 1'b0};
    vecs[9]  = '{1'b1, 2'b10, 6'h09, 32'h00000F0F, 32'h0000FFFF, 32'hAAAA5555, 1'b0, 1'b0, 2, 4, 32'hAAAA0F0F, 5, 32'hAAAA5555, 1'b0};
    vecs[10] = '{1'b1, 2'b01, 6'h0A, 32'h00000000, 32'h00000000, 32'h0F0F0F0F, 1'b1, 1'b0, 2, 0, 32'h00000000, 4, 32'h0F0F0F0F, 1'b1};

    for (int i = 0; i < 64; i++) tmem[i] = 32'h0;
    reset = 1'b1; cv = 1'b0; tb_sel = 1'b0; rsp_ready = 1'b1; tb_rerr = 1'b0; tb_werr = 1'b0;
    op = 2'b00; caddr = 6'd0; cdata = 32'h0; cmask = 32'h0;
    #12;
    chk("reset_flags0", {26'd0, wr0, rd0, rsp_valid0, rsp_err0, busy0, cmd_ready0}, 32'd1);
    chk("reset_bus0", {26'd0, addr0} | wdata0 | rsp_data0, 32'h0);
    chk("reset_flags1", {26'd0, wr1, rd1, rsp_valid1, rsp_err1, busy1, cmd_ready1}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Back-pressure: park one read in RESP, then offer FIFO_DEPTH+1 more commands
    for (int i = 0; i < 6; i++) tmem[6'h30 + i] = 32'hC0DE0030 + i;
    @(negedge clk);
    tb_sel = 1'b0; rsp_ready = 1'b0; tb_rerr = 1'b0; tb_werr = 1'b0;
    op = 2'b01; caddr = 6'h30; cv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cv = 1'b0;
    repeat (3) @(negedge clk);
    acc = 0; rv_held = 1'b1; last_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rv_held  = rv_held & rsp_valid0;
      last_rdy = cmd_ready0;
      if (cmd_ready0) acc++;
      caddr = 6'h31 + 6'(i); cv = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    cv = 1'b0;
    chk("full_accepted", acc, 4);
    chk("full_ready_low", {31'd0, last_rdy}, 32'd0);
    chk("full_rsp_held", {31'd0, rv_held & rsp_valid0}, 32'd1);
    chk("full_busy", {31'd0, busy0}, 32'd1);
    rsp_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid0 && n < 8) begin resp[n] = rsp_data0; n++; end
      @(negedge clk);
    end
    chk("order_count", n, 5);
    for (int j = 0; j < 5; j++) chk($sformatf("order_rsp%0d", j), resp[j], 32'hC0DE0030 + j);

    // Reset during RD with a second command queued
    tmem[6'h12] = 32'h55AA55AA;
    op = 2'b01; caddr = 6'h12; cv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    caddr = 6'h13;
    @(posedge clk);
    @(negedge clk);
    cv = 1'b0;
    chk("rst_mid_rd_before", {31'd0, rd0}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_rd", {31'd0, rd0}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy0}, 32'd0);
    chk("rst_mid_flags", {29'd0, rsp_valid0, cmd_ready0, wr0}, 32'd2);
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rd0 || wr0 || rsp_valid0 || busy0) quiet = 1'b0;
    end
    chk("rst_mid_quiet", {31'd0, quiet}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ehl_gpio_master.md
EHL_GPIO_MASTER -- requirements
Module: ehl_gpio_master

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the bus, command and response data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the command FIFO depth; legal values are powers of 2 and at least 2.
REQ-003 SHALL have parameter READ_LATENCY, default 0: 0 means target read data and err are valid in the rd cycle; 1 means they are valid one cycle after rd (registered-output target).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have these ports, clock and reset first:
  clk  in  1  core clock, all state on rising edge
  reset  in  1  asynchronous active-high reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command FIFO can accept
  cmd_op  in  2  00 write, 01 read, 10 read-modify-write (RMW), 11 reserved
  cmd_addr  in  6  target register address
  cmd_data  in  WIDTH  write data, or RMW new bits
  cmd_mask  in  WIDTH  RMW bit mask (ignored for other ops)
  wr  out  1  single-cycle write strobe to target
  rd  out  1  single-cycle read strobe to target
  addr  out  6  target address
  bus_wdata  out  WIDTH  target write data
  bus_rdata  in  WIDTH  target read data
  bus_err  in  1  target error flag
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed
  rsp_data  out  WIDTH  response data
  rsp_err  out  1  response error
  busy  out  1  FIFO non-empty or FSM not IDLE

Function
REQ-006 SHALL push the command into the FIFO on each rising edge where cmd_valid and cmd_ready are both 1; cmd_ready SHALL equal !full.
REQ-007 SHALL allow a push and a pop in the same cycle when the FIFO is non-empty; when full, cmd_ready=0 and no push occurs, even if a pop happens in that cycle.
REQ-008 SHALL implement FSM states IDLE, RD, RDWAIT, WR, RESP.
REQ-009 In IDLE with the FIFO non-empty, SHALL pop one entry and go to:
  - WR for op 00;
  - RD for op 01 or 10;
  - RESP for op 11, with rsp_err=1 and rsp_data=0, issuing no strobe.
REQ-010 In RD, SHALL assert rd=1 with addr for exactly one cycle.
  - READ_LATENCY=0: capture bus_rdata and bus_err in that cycle.
  - READ_LATENCY=1: go to RDWAIT (rd=0) and capture there.
REQ-011 After the capture, SHALL go to RESP for a read, with rsp_data=captured data and rsp_err=captured err.
REQ-012 After the capture, an RMW SHALL do the following.
  - If err=1: go to RESP with rsp_err=1 and rsp_data=captured data, and issue no wr.
  - Otherwise: go to WR with bus_wdata=(old & ~cmd_mask) | (cmd_data & cmd_mask).
REQ-013 In WR, SHALL assert wr=1 with addr and bus_wdata for exactly one cycle and sample bus_err in that cycle.
  - Plain write: rsp_data=0.
  - RMW: rsp_data=old read value.
  - Both: rsp_err=sampled err; next state RESP.
REQ-014 In RESP, SHALL hold rsp_valid=1 with rsp_data and rsp_err stable until rsp_ready=1, then go to IDLE; no pop occurs in RESP.
REQ-015 wr and rd SHALL never be 1 in the same cycle; addr and bus_wdata SHALL be 0 in cycles with no strobe.
REQ-016 Latency, with the command handshake at cycle T and an empty FIFO and IDLE FSM:
  - strobe in cycle T+2;
  - write or read (READ_LATENCY=0): rsp_valid in T+3;
  - read (READ_LATENCY=1): rsp_valid in T+4;
  - RMW (READ_LATENCY=0): wr in T+3 and rsp_valid in T+4.
REQ-017 Commands SHALL complete strictly in acceptance order, one outstanding target access at a time.
REQ-018 busy SHALL be combinational: (FIFO non-empty) | (state != IDLE).

Reset
REQ-019 While reset=1, SHALL asynchronously clear the FIFO, set the FSM to IDLE, and drive wr, rd, addr, bus_wdata, rsp_valid, rsp_data, rsp_err and busy to 0 and cmd_ready to 1.
REQ-020 A reset asserted mid-operation SHALL abort the command with no further strobe or response, and queued commands SHALL be discarded.

Verification
REQ-021 Write, READ_LATENCY=0: cmd op00 addr 0x04 data 0xA5A5A5A5 -> wr=1, addr=0x04, bus_wdata=0xA5A5A5A5 at T+2; rsp_valid at T+3 with rsp_data=0 and rsp_err=0.
REQ-022 Read, READ_LATENCY=1, target returning 0x12345678: cmd op01 addr 0x08 -> rd=1 at T+2 only; rsp_valid at T+4 with rsp_data=0x12345678.
REQ-023 RMW, old=0xFF00FF00, data=0x0000FFFF, mask=0x000000F0 -> wr data 0xFF00FFF0; rsp_data=0xFF00FF00.
REQ-024 RMW with bus_err=1 on the read -> no wr issued; rsp_err=1.
REQ-025 Full and back-pressure: push FIFO_DEPTH+1 commands while holding rsp_ready=0.
  - cmd_ready drops after FIFO_DEPTH accepted pushes.
  - rsp_valid stays asserted.
  - On releasing rsp_ready, responses arrive in order.
REQ-026 Reserved op and reset: op11 -> rsp_err=1 with no strobes; reset asserted during RD -> rd=0 immediately, busy=0, no response.
